// File: rtl/pe_conv_multi_fil.sv
// pe_conv_multi_fil: 1D-convolution processing element.
// Buffers up to NUM_FIL filters and one ifmap row in local scratchpads, then
// evaluates every strided window against every loaded filter (filter index
// inner, window offset outer). Each result may be summed with an incoming
// partial sum before it is handed to the output stream.
//
// Ports:
//   clk, clr_n          clock (rising edge), synchronous active-low reset
//   start               begin a job from IDLE, latching the configuration
//   filter_size, stride, num_fil, acum   job configuration
//   ifm_*               ifmap stream in  (valid/ready, data, last)
//   fil_*               filter stream in (valid/ready, data), filter-major
//   psum_*              partial-sum stream in (valid/ready, data)
//   out_*               result stream out (valid/ready, data, filter index)
//   busy, done          status: not idle / one-cycle end-of-job pulse
//
// Build option: define PE_PSUM_SAT_EN to make MAC accumulation and the psum
// addition saturate at 2^PSUM_WIDTH-1 instead of wrapping.

module pe_conv_multi_fil #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned IFM_DEPTH  = 16,
   parameter int unsigned F_MAX      = 4,
   parameter int unsigned NUM_FIL    = 4,
   parameter int unsigned PSUM_WIDTH = 20,
   parameter int unsigned S_W        = 2
) (
   input  logic                          clk,
   input  logic                          clr_n,
   input  logic                          start,
   input  logic [$clog2(F_MAX+1)-1:0]    filter_size,
   input  logic [S_W-1:0]                stride,
   input  logic [$clog2(NUM_FIL+1)-1:0]  num_fil,
   input  logic                          acum,
   input  logic                          ifm_valid,
   output logic                          ifm_ready,
   input  logic [DATA_WIDTH-1:0]         ifm_data,
   input  logic                          ifm_last,
   input  logic                          fil_valid,
   output logic                          fil_ready,
   input  logic [DATA_WIDTH-1:0]         fil_data,
   input  logic                          psum_valid,
   output logic                          psum_ready,
   input  logic [PSUM_WIDTH-1:0]         psum_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [PSUM_WIDTH-1:0]         out_data,
   output logic [$clog2(NUM_FIL)-1:0]    out_fil,
   output logic                          busy,
   output logic                          done
);

   localparam int unsigned FSW = $clog2(F_MAX + 1);
   localparam int unsigned NFW = $clog2(NUM_FIL + 1);
   localparam int unsigned OFW = $clog2(NUM_FIL);
   localparam int unsigned IA  = $clog2(IFM_DEPTH);
   localparam int unsigned CW  = $clog2(IFM_DEPTH + 1);
   localparam int unsigned BW  = CW + S_W + 1;   // room for base+stride+size
   localparam int unsigned FD  = F_MAX * NUM_FIL;
   localparam int unsigned FA  = $clog2(FD);
   localparam int unsigned PW  = 2 * DATA_WIDTH;

   typedef enum logic [2:0] {
      IDLE, LOAD_FIL, LOAD_IFM, MAC, EMIT, DONE
   } state_t;

   state_t state, nxt;

   logic [FSW-1:0]        fs_r, t_cnt;
   logic [S_W-1:0]        st_r;
   logic [NFW-1:0]        nf_r, k_cnt;
   logic                  acum_r;
   logic [CW-1:0]         ifm_cnt, cnt_inc;
   logic [BW-1:0]         base, win_next_end;
   logic [PSUM_WIDTH-1:0] acc, res, sum_in;
   logic                  have_psum, need_psum;
   logic                  t_last, k_last, win_end;
   logic                  fil_take, ifm_take, psum_take, out_take;
   logic [FA-1:0]         fil_addr;
   logic [IA-1:0]         ifm_raddr;
   logic [PW-1:0]         prod;

   logic [DATA_WIDTH-1:0] fil_mem [FD];
   logic [DATA_WIDTH-1:0] ifm_mem [IFM_DEPTH];

   function automatic logic [PSUM_WIDTH-1:0] add_f(input logic [PSUM_WIDTH-1:0] a,
                                                   input logic [PSUM_WIDTH-1:0] b);
      logic [PSUM_WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
`ifdef PE_PSUM_SAT_EN
      return s[PSUM_WIDTH] ? '1 : s[PSUM_WIDTH-1:0];
`else
      return s[PSUM_WIDTH-1:0];
`endif
   endfunction

   assign t_last       = (t_cnt == fs_r - 1'b1);
   assign k_last       = (k_cnt == nf_r - 1'b1);
   assign cnt_inc      = ifm_cnt + 1'b1;
   // End of the row: the window after the current one would overrun the data.
   assign win_next_end = base + BW'(st_r) + BW'(fs_r);
   assign win_end      = (win_next_end > BW'(ifm_cnt));

   // Same addressing for filter writes (LOAD_FIL) and reads (MAC).
   assign fil_addr  = FA'(k_cnt * F_MAX + t_cnt);
   assign ifm_raddr = IA'(base + BW'(t_cnt));
   assign prod      = PW'(ifm_mem[ifm_raddr]) * PW'(fil_mem[fil_addr]);
   assign sum_in    = add_f(acc, psum_data);
   assign need_psum = acum_r & ~have_psum;

   assign fil_take  = fil_valid  & fil_ready;
   assign ifm_take  = ifm_valid  & ifm_ready;
   assign psum_take = psum_valid & psum_ready;
   assign out_take  = out_valid  & out_ready;

   always_comb begin
      nxt        = state;
      fil_ready  = 1'b0;
      ifm_ready  = 1'b0;
      psum_ready = 1'b0;
      out_valid  = 1'b0;
      out_data   = '0;
      out_fil    = '0;
      busy       = (state != IDLE);
      done       = (state == DONE);
      case (state)
         IDLE: begin
            if (start) nxt = LOAD_FIL;
         end
         LOAD_FIL: begin
            fil_ready = 1'b1;
            if (fil_valid && t_last && k_last) nxt = LOAD_IFM;
         end
         LOAD_IFM: begin
            ifm_ready = 1'b1;
            if (ifm_valid && (ifm_last || cnt_inc == CW'(IFM_DEPTH)))
               nxt = (cnt_inc < CW'(fs_r)) ? DONE : MAC;
         end
         MAC: begin
            if (t_last) nxt = EMIT;
         end
         EMIT: begin
            // The psum is consumed in the same cycle the result is first
            // offered; once taken the sum is registered so it stays stable
            // while out_ready is held low.
            psum_ready = need_psum;
            out_valid  = need_psum ? psum_valid : 1'b1;
            out_data   = have_psum ? res : (acum_r ? sum_in : acc);
            out_fil    = k_cnt[OFW-1:0];
            if (out_valid && out_ready)
               nxt = (k_last && win_end) ? DONE : MAC;
         end
         DONE: begin
            nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state     <= IDLE;
         fs_r      <= '0;
         st_r      <= '0;
         nf_r      <= '0;
         acum_r    <= 1'b0;
         t_cnt     <= '0;
         k_cnt     <= '0;
         ifm_cnt   <= '0;
         base      <= '0;
         acc       <= '0;
         res       <= '0;
         have_psum <= 1'b0;
      end else begin
         state <= nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  fs_r      <= (filter_size == '0) ? FSW'(1) :
                               (filter_size > FSW'(F_MAX)) ? FSW'(F_MAX) : filter_size;
                  st_r      <= (stride == '0) ? S_W'(1) : stride;
                  nf_r      <= (num_fil == '0) ? NFW'(1) :
                               (num_fil > NFW'(NUM_FIL)) ? NFW'(NUM_FIL) : num_fil;
                  acum_r    <= acum;
                  t_cnt     <= '0;
                  k_cnt     <= '0;
                  ifm_cnt   <= '0;
                  base      <= '0;
                  have_psum <= 1'b0;
               end
            end
            LOAD_FIL: begin
               if (fil_take) begin
                  if (t_last) begin
                     t_cnt <= '0;
                     k_cnt <= k_last ? '0 : k_cnt + 1'b1;
                  end else begin
                     t_cnt <= t_cnt + 1'b1;
                  end
               end
            end
            LOAD_IFM: begin
               if (ifm_take) ifm_cnt <= cnt_inc;
            end
            MAC: begin
               acc   <= add_f((t_cnt == '0) ? '0 : acc, PSUM_WIDTH'(prod));
               t_cnt <= t_last ? '0 : t_cnt + 1'b1;
            end
            EMIT: begin
               if (psum_take) begin
                  res       <= sum_in;
                  have_psum <= 1'b1;
               end
               if (out_take) begin
                  have_psum <= 1'b0;
                  if (k_last) begin
                     k_cnt <= '0;
                     base  <= base + BW'(st_r);
                  end else begin
                     k_cnt <= k_cnt + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Scratchpads hold no reset; their contents are only read after being written.
   always_ff @(posedge clk) begin
      if (fil_take) fil_mem[fil_addr] <= fil_data;
      if (ifm_take) ifm_mem[ifm_cnt[IA-1:0]] <= ifm_data;
   end

endmodule

// File: tb/tb_pe_conv_multi_fil.sv
// Directed testbench for pe_conv_multi_fil with hand-computed expectations.
module tb_pe_conv_multi_fil;

   logic        clk = 1'b0;
   logic        clr_n, start, acum;
   logic [2:0]  filter_size, num_fil;
   logic [1:0]  stride;
   logic        ifm_valid, ifm_ready, ifm_last;
   logic [7:0]  ifm_data, fil_data;
   logic        fil_valid, fil_ready;
   logic        psum_valid, psum_ready;
   logic [19:0] psum_data, out_data;
   logic        out_valid, out_ready;
   logic [1:0]  out_fil;
   logic        busy, done;

   always #5 clk = ~clk;

   pe_conv_multi_fil #(
      .DATA_WIDTH(8), .IFM_DEPTH(16), .F_MAX(4), .NUM_FIL(4), .PSUM_WIDTH(20), .S_W(2)
   ) dut (
      .clk(clk), .clr_n(clr_n), .start(start), .filter_size(filter_size),
      .stride(stride), .num_fil(num_fil), .acum(acum),
      .ifm_valid(ifm_valid), .ifm_ready(ifm_ready), .ifm_data(ifm_data), .ifm_last(ifm_last),
      .fil_valid(fil_valid), .fil_ready(fil_ready), .fil_data(fil_data),
      .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_fil(out_fil),
      .busy(busy), .done(done)
   );

   int n_vec = 0;
   int n_bad = 0;
   int fil_v [16];
   int ifm_v [20];
   int exp_d [20];
   int exp_f [20];
   int psum_v[20];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_out_valid"},  out_valid,  0);
      check({tag, "_out_data"},   out_data,   0);
      check({tag, "_out_fil"},    out_fil,    0);
      check({tag, "_fil_ready"},  fil_ready,  0);
      check({tag, "_ifm_ready"},  ifm_ready,  0);
      check({tag, "_psum_ready"}, psum_ready, 0);
      check({tag, "_busy"},       busy,       0);
      check({tag, "_done"},       done,       0);
   endtask

   task automatic send_fil(input int v);
      int n = 0;
      fil_valid = 1'b1;
      fil_data  = 8'(v);
      while (!fil_ready && n < 20) begin @(negedge clk); n++; end
      check("fil_ready", fil_ready, 1);
      @(negedge clk);
      fil_valid = 1'b0;
   endtask

   task automatic send_ifm(input int v, input bit last);
      int n = 0;
      ifm_valid = 1'b1;
      ifm_data  = 8'(v);
      ifm_last  = last;
      while (!ifm_ready && n < 20) begin @(negedge clk); n++; end
      check("ifm_ready", ifm_ready, 1);
      @(negedge clk);
      ifm_valid = 1'b0;
      ifm_last  = 1'b0;
   endtask

   task automatic get_out(input string tag, input int i, input int ac, input bit hold,
                          output int lat);
      int n = 0;
      psum_valid = ac[0];
      psum_data  = 20'(psum_v[i]);
      out_ready  = !hold;
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      lat = n;
      check($sformatf("%s_valid%0d", tag, i), out_valid, 1);
      check($sformatf("%s_data%0d",  tag, i), out_data, exp_d[i]);
      check($sformatf("%s_fil%0d",   tag, i), out_fil,  exp_f[i]);
      if (hold) begin
         @(negedge clk);
         psum_valid = 1'b0;
         repeat (5) begin
            check($sformatf("%s_hold_valid%0d", tag, i), out_valid, 1);
            check($sformatf("%s_hold_data%0d",  tag, i), out_data, exp_d[i]);
            check($sformatf("%s_hold_psrdy%0d", tag, i), psum_ready, 0);
            @(negedge clk);
         end
         out_ready = 1'b1;
         check($sformatf("%s_rel_data%0d", tag, i), out_data, exp_d[i]);
      end
      @(negedge clk);
      out_ready  = 1'b0;
      psum_valid = 1'b0;
   endtask

   task automatic run_job(input string tag, input int fs, input int st, input int nf,
                          input int ac, input int nfil, input int nifm, input bit use_last,
                          input int extra, input int nout, input int hold_at);
      int lat;
      int n = 0;
      int stray = 0;
      filter_size = 3'(fs);
      stride      = 2'(st);
      num_fil     = 3'(nf);
      acum        = ac[0];
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < nfil; i++) send_fil(fil_v[i]);
      for (int i = 0; i < nifm; i++) send_ifm(ifm_v[i], use_last && (i == nifm - 1));
      if (extra > 0) begin
         // Words offered after the scratchpad has filled must be refused.
         ifm_valid = 1'b1;
         ifm_data  = 8'hAA;
         repeat (extra) begin
            check({tag, "_full_ifm_ready"}, ifm_ready, 0);
            @(negedge clk);
         end
         ifm_valid = 1'b0;
      end
      for (int i = 0; i < nout; i++) begin
         get_out(tag, i, ac, (i == hold_at), lat);
         // Waits counted from the first MAC cycle: filter_size MAC cycles, then EMIT.
         if (i == 0 && extra == 0) check({tag, "_latency"}, lat, fs);
      end
      out_ready = 1'b1;
      while (!done && n < 200) begin
         if (out_valid) stray++;
         @(negedge clk);
         n++;
      end
      check({tag, "_done"}, done, 1);
      check({tag, "_stray_out"}, stray, 0);
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      int stray;
      clr_n = 1'b0; start = 1'b0; acum = 1'b0;
      filter_size = '0; num_fil = '0; stride = '0;
      ifm_valid = 1'b0; ifm_last = 1'b0; ifm_data = '0;
      fil_valid = 1'b0; fil_data = '0;
      psum_valid = 1'b0; psum_data = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_idle("reset");
      clr_n = 1'b1;
      @(negedge clk);

      // Single filter, stride 1
      fil_v[0:2] = '{1, 2, 3};
      ifm_v[0:4] = '{1, 2, 3, 4, 5};
      exp_d[0:2] = '{14, 20, 26};
      exp_f[0:2] = '{0, 0, 0};
      run_job("s1", 3, 1, 1, 0, 3, 5, 1, 0, 3, -1);

      // Stride 2
      exp_d[0:1] = '{14, 26};
      exp_f[0:1] = '{0, 0};
      run_job("s2", 3, 2, 1, 0, 3, 5, 1, 0, 2, -1);

      // Two filters, filter index inner
      fil_v[0:5] = '{1, 1, 1, 0, 0, 1};
      exp_d[0:5] = '{6, 3, 9, 4, 12, 5};
      exp_f[0:5] = '{0, 1, 0, 1, 0, 1};
      run_job("f2", 3, 1, 2, 0, 6, 5, 1, 0, 6, -1);

      // Accumulate with backpressure on the second result
      fil_v[0:2]  = '{1, 2, 3};
      psum_v[0:2] = '{100, 200, 300};
      exp_d[0:2]  = '{114, 220, 326};
      exp_f[0:2]  = '{0, 0, 0};
      run_job("acc", 3, 1, 1, 1, 3, 5, 1, 0, 3, 1);

      // Row shorter than the filter: no results
      ifm_v[0:1] = '{1, 2};
      run_job("short", 3, 1, 1, 0, 3, 2, 1, 0, 0, -1);

      // 20 words offered without last: 16 accepted, one result per element
      fil_v[0] = 1;
      for (int i = 0; i < 16; i++) begin
         ifm_v[i] = i + 1;
         exp_d[i] = i + 1;
         exp_f[i] = 0;
      end
      run_job("full", 1, 1, 1, 0, 1, 16, 0, 4, 16, -1);

      // psum addition overflow
      fil_v[0:2] = '{1, 2, 3};
      ifm_v[0:2] = '{1, 2, 3};
      psum_v[0]  = 1048570;
`ifdef PE_PSUM_SAT_EN
      exp_d[0] = 1048575;
`else
      exp_d[0] = 8;
`endif
      exp_f[0] = 0;
      run_job("sat", 3, 1, 1, 1, 3, 3, 1, 0, 1, -1);

      // Reset during MAC aborts the job
      ifm_v[0:4]  = '{1, 2, 3, 4, 5};
      filter_size = 3'd3; stride = 2'd1; num_fil = 3'd1; acum = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) send_fil(fil_v[i]);
      for (int i = 0; i < 5; i++) send_ifm(ifm_v[i], i == 4);
      @(negedge clk);
      check("midrst_busy_before", busy, 1);
      clr_n = 1'b0;
      @(negedge clk);
      check_idle("midrst");
      clr_n     = 1'b1;
      out_ready = 1'b1;
      stray     = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid || busy) stray++;
      end
      check("midrst_no_activity", stray, 0);
      out_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
